spi_req_arbiter: RTL and testbench

Shares one spi_master between NUM_REQ independent requesters. Each requester submits a frame word over a req/ack handshake. Arbitration is round-robin. The winner's word is issued to the master as a one-cycle newd pulse with din, and cs from the master is monitored to detect frame start and end. The block sits between the client logic and spi_master, in the same clk domain, and replaces direct newd/din drive.

---
 rtl/spi_pkg.sv | 37 +++
 rtl/spi_req_arbiter_if.sv | 22 ++
 rtl/rr_arbiter_core.sv | 29 ++
 rtl/spi_req_arbiter.sv | 116 +++++++++++
 tb/tb_spi_req_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI request arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   SPI_FRAME_W  - frame width shared with spi_master/spi_slave
//   rr_pick()    - round-robin winner index from a request vector and pointer
package spi_pkg;

  localparam int SPI_FRAME_W = 12;
  localparam int MAX_REQ     = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_END   = 2'd2,
    DONE       = 2'd3
  } arb_state_t;

  // Scan ptr, ptr+1, ... modulo n and return the first requesting index.
  // Returns ptr when nothing is requesting; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      idx = 3'((32'(ptr) + off) % n);
      if (off < n && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if: requester-side handshake plus spi_master start/cs signals.
//   master - client/spi_master side: drives req, req_data, cs_in
//   slave  - arbiter side: drives grant, ack, err, busy, newd, din
interface spi_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 12
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        ack;
  logic                      err;
  logic                      busy;
  logic                      newd;
  logic [DATA_W-1:0]         din;
  logic                      cs_in;

  modport master (output req, req_data, cs_in,
                  input  grant, ack, err, busy, newd, din);
  modport slave  (input  req, req_data, cs_in,
                  output grant, ack, err, busy, newd, din);
endinterface

// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core: combinational round-robin pick.
//   req_i  - request vector
//   ptr_i  - highest-priority index
//   gnt_o  - one-hot winner
//   idx_o  - winner index
//   vld_o  - at least one request present
module rr_arbiter_core
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               vld_o
);
  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         ptr_ext;
  logic [2:0]         pick;

  assign req_ext = MAX_REQ'(req_i);
  assign ptr_ext = 3'(ptr_i);
  assign pick    = rr_pick(req_ext, ptr_ext, NUM_REQ);
  assign idx_o   = pick[PTR_W-1:0];
  assign vld_o   = |req_i;
  assign gnt_o   = vld_o ? (NUM_REQ'(1) << idx_o) : '0;
endmodule

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one spi_master between NUM_REQ requesters.
//   clk, rst - clock, async active-high reset
//   bus      - slave modport: req/req_data in, grant/ack/err/busy out,
//              newd/din to spi_master, cs_in from spi_master
// A granted word is latched into din and announced with a one-cycle newd.
// cs_in falling marks frame start, rising marks frame end; each wait state
// is bounded by TIMEOUT_CYC cycles, after which the frame is acked with err.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = SPI_FRAME_W,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic clk,
  input logic rst,
  spi_req_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t         state_q;
  logic [PTR_W-1:0]   ptr_q, owner_q;
  logic [TMR_W-1:0]   timer_q;
  logic [NUM_REQ-1:0] grant_q, ack_q;
  logic               err_q, busy_q, newd_q;
  logic [DATA_W-1:0]  din_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               tmo;

  rr_arbiter_core #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_core (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign tmo = (timer_q == TMR_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      timer_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      newd_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      // Pulse outputs default low; set only on the transition that owns them.
      newd_q <= 1'b0;
      ack_q  <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_gnt;
            owner_q <= pick_idx;
            din_q   <= bus.req_data[pick_idx*DATA_W +: DATA_W];
            newd_q  <= 1'b1;
            timer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= WAIT_START;
          end
        end
        WAIT_START: begin
          // A stale-low cs_in counts as a start so the frame cannot wedge.
          if (!bus.cs_in) begin
            timer_q <= '0;
            state_q <= WAIT_END;
          end else if (tmo) begin
            ack_q   <= grant_q;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        WAIT_END: begin
          if (bus.cs_in) begin
            ack_q   <= grant_q;
            state_q <= DONE;
          end else if (tmo) begin
            ack_q   <= grant_q;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        DONE: begin
          // ack is high during this cycle; grant still overlaps it.
          ptr_q   <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign bus.newd  = newd_q;
  assign bus.din   = din_q;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: scoreboard bench. Expected frames (owner, word, err)
// are queued when requests are raised and popped on each newd; the ack of
// the frame in flight is compared against the popped entry. A small
// spi_master model drops cs_in 3 cycles after newd and raises it later.
module tb_spi_req_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 12;
  localparam int TO  = 15;
  localparam int LOW = 10;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_req_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  spi_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic have_cur = 1'b0;
  int   rem[NR];
  int   cs_phase = 0;
  int   cs_cnt   = 0;
  logic hang_cs  = 1'b0;
  int   newd_cyc = 0;
  int   rise_cyc = 0;
  logic prev_newd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.gnt  = NR'(1) << i;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] d, input int n);
    bus.req_data[i*DW +: DW] = d;
    rem[i]     = n;
    bus.req[i] = 1'b1;
  endtask

  // One clock: advance the cs model, then score whatever the DUT shows.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cs_phase == 1) begin
      cs_cnt++;
      if (cs_cnt == 3) begin bus.cs_in = 1'b0; cs_phase = 2; cs_cnt = 0; end
    end else if (cs_phase == 2) begin
      cs_cnt++;
      if (cs_cnt == LOW) begin bus.cs_in = 1'b1; rise_cyc = cyc; cs_phase = 0; end
    end
    if (bus.newd) begin
      chk("newd_width", 32'(prev_newd), 0);
      if (exp_q.size() == 0) chk("newd_unexpected", 1, 0);
      else begin
        cur = exp_q.pop_front();
        have_cur = 1'b1;
        chk("grant", 32'(bus.grant), 32'(cur.gnt));
        chk("din", 32'(bus.din), 32'(cur.data));
        newd_cyc = cyc;
        if (!hang_cs) begin cs_phase = 1; cs_cnt = 0; end
      end
    end
    prev_newd = bus.newd;
    if (|bus.ack) begin
      if (!have_cur) chk("ack_unexpected", 32'(bus.ack), 0);
      else begin
        chk("ack", 32'(bus.ack), 32'(cur.gnt));
        chk("err", 32'(bus.err), 32'(cur.err));
        chk("ack_grant_overlap", 32'(bus.grant), 32'(cur.gnt));
        chk("din_hold", 32'(bus.din), 32'(cur.data));
        if (cur.err) chk("timeout_lat", 32'(cyc - newd_cyc), TO + 1);
        else         chk("ack_lat", 32'(cyc - rise_cyc), 1);
        have_cur = 1'b0;
      end
      for (int i = 0; i < NR; i++)
        if (bus.ack[i] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) bus.req[i] = 1'b0;
        end
    end else if (bus.err) begin
      chk("err_without_ack", 1, 0);
    end
  endtask

  task automatic wait_done(input int budget);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && !have_cur && !bus.busy && bus.req == '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("wait_budget", 0, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    logic ok;
    bus.req      = '0;
    bus.req_data = '0;
    bus.cs_in    = 1'b1;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    #12;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_ack",   32'(bus.ack), 0);
    chk("rst_err",   32'(bus.err), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_newd",  32'(bus.newd), 0);
    chk("rst_din",   32'(bus.din), 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Single request, one-cycle request-to-newd latency.
    set_req(2, 12'hA5C, 1);
    push(2, 12'hA5C, 1'b0);
    tick();
    chk("newd_lat", 32'(bus.newd), 1);
    wait_done(100);

    // All four at once from ptr=0: served 0,1,2,3.
    pulse_reset();
    for (int i = 0; i < NR; i++) begin
      set_req(i, DW'(i + 1), 1);
      push(i, DW'(i + 1), 1'b0);
    end
    wait_done(300);

    // ptr back at 0: 0 beats 3 when both request.
    set_req(3, 12'h333, 1);
    set_req(0, 12'h0F0, 1);
    push(0, 12'h0F0, 1'b0);
    push(3, 12'h333, 1'b0);
    wait_done(200);

    // Fairness: req[1] held for two frames, req[0] joins mid-frame.
    set_req(1, 12'h111, 2);
    push(1, 12'h111, 1'b0);
    tick();
    tick();
    set_req(0, 12'h222, 1);
    push(0, 12'h222, 1'b0);
    push(1, 12'h111, 1'b0);
    wait_done(300);

    // Timeout: spi_master never drops cs; then a normal frame.
    hang_cs = 1'b1;
    set_req(2, 12'hBAD, 1);
    push(2, 12'hBAD, 1'b1);
    wait_done(100);
    hang_cs = 1'b0;
    tick();
    chk("busy_after_tmo", 32'(bus.busy), 0);
    set_req(3, 12'h5A5, 1);
    push(3, 12'h5A5, 1'b0);
    wait_done(100);

    // Drop req and scribble req_data mid-frame.
    set_req(0, 12'h3C3, 1);
    push(0, 12'h3C3, 1'b0);
    tick();
    tick();
    bus.req[0] = 1'b0;
    bus.req_data[0 +: DW] = 12'hFFF;
    wait_done(100);

    // Reset during WAIT_END.
    set_req(1, 12'h777, 1);
    push(1, 12'h777, 1'b0);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      if (bus.cs_in == 1'b0) ok = 1'b1;
    end
    if (!ok) chk("cs_fall_budget", 0, 1);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_busy",  32'(bus.busy), 0);
    chk("mid_rst_newd",  32'(bus.newd), 0);
    exp_q.delete();
    have_cur  = 1'b0;
    cs_phase  = 0;
    bus.cs_in = 1'b1;
    bus.req   = '0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    tick();
    tick();
    set_req(3, 12'h3A3, 1);
    set_req(0, 12'h0A0, 1);
    push(0, 12'h0A0, 1'b0);
    push(3, 12'h3A3, 1'b0);
    @(negedge clk) rst = 1'b0;
    wait_done(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end
endmodule
